// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use, branch/jump-in-ID operand, and MUL/DIV structural hazards.
// Drives the PC / IF-ID enables and the IF-ID / ID-EX bubble controls.
// Sequences multi-cycle fetch flushes after a taken branch or jump.
// Tracks MUL/DIV busy time and keeps a saturating stall-cycle counter.
module hazard_ctrl_param #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_LATENCY   = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_RegWrite,
    input  logic [REG_AW-1:0] ID_EX_WriteReg,
    input  logic              EX_MEM_MemRead,
    input  logic [REG_AW-1:0] EX_MEM_WriteReg,
    input  logic [REG_AW-1:0] IF_ID_RegRs,
    input  logic [REG_AW-1:0] IF_ID_RegRt,
    input  logic              IF_ID_UseRs,
    input  logic              IF_ID_UseRt,
    input  logic              IF_ID_UseHiLo,
    input  logic              IDcontrol_Branch,
    input  logic              IDcontrol_Jump,
    input  logic              Branch_Taken,
    input  logic              MD_Start,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Clear,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int         MD_W       = 6;
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [1:0]        flush_cnt, flush_cnt_nxt;
    logic [MD_W-1:0]   md_cnt;

    logic id_valid;
    logic m_ex, m_mem;
    logic load_use, br_any, br_ex, br_mem, md_hz;
    logic stall, redirect;

    // A source only conflicts when it is really read and the producer is not $0.
    function automatic logic src_match(input logic use_f,
                                       input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] dst);
        return use_f && (src == dst) && (dst != '0);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign md_busy = (md_cnt != '0);

    // Hazard detection; the ID slot is ignored while it holds a flush bubble or in reset.
    always_comb begin
        id_valid = ~reset & (state == IDLE);
        m_ex     = src_match(IF_ID_UseRs, IF_ID_RegRs, ID_EX_WriteReg) |
                   src_match(IF_ID_UseRt, IF_ID_RegRt, ID_EX_WriteReg);
        m_mem    = src_match(IF_ID_UseRs, IF_ID_RegRs, EX_MEM_WriteReg) |
                   src_match(IF_ID_UseRt, IF_ID_RegRt, EX_MEM_WriteReg);
        br_any   = IDcontrol_Branch | IDcontrol_Jump;
        load_use = ID_EX_MemRead & m_ex;
        br_ex    = br_any & ID_EX_RegWrite & m_ex;
        br_mem   = br_any & EX_MEM_MemRead & m_mem;
        md_hz    = md_busy & IF_ID_UseHiLo;
        stall    = id_valid & (load_use | br_ex | br_mem | md_hz);
        redirect = id_valid & ~stall &
                   (IDcontrol_Jump | (IDcontrol_Branch & Branch_Taken));
    end

    // Flush FSM next state and Mealy control outputs.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        PCWrite       = ~stall;
        IF_ID_Write   = ~stall;
        ID_EX_Clear   = stall;
        IF_ID_Flush   = 1'b0;
        case (state)
            IDLE: begin
                IF_ID_Flush = redirect;
                if (redirect && (FLUSH_CYCLES > 1)) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_INIT;
                end
            end
            FLUSH: begin
                IF_ID_Flush = 1'b1;
                PCWrite     = 1'b1;
                if (flush_cnt <= 2'd1) begin
                    state_nxt     = IDLE;
                    flush_cnt_nxt = 2'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 2'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = 2'd0;
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // MUL/DIV busy tracker; a new start always reloads the full latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (MD_Start) begin
            md_cnt <= MD_W'(MD_LATENCY);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed, table-driven bench for hazard_ctrl_param.
// Configured with FLUSH_CYCLES=3, MD_LATENCY=4, CNT_W=4.
module tb_hazard_ctrl_param;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead;
    logic [REG_AW-1:0] ID_EX_WriteReg, EX_MEM_WriteReg, IF_ID_RegRs, IF_ID_RegRt;
    logic              IF_ID_UseRs, IF_ID_UseRt, IF_ID_UseHiLo;
    logic              IDcontrol_Branch, IDcontrol_Jump, Branch_Taken, MD_Start;
    logic              PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Clear, md_busy;
    logic [CNT_W-1:0]  stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_param #(
        .REG_AW(REG_AW), .FLUSH_CYCLES(3), .MD_LATENCY(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteReg(EX_MEM_WriteReg), .IF_ID_RegRs(IF_ID_RegRs),
        .IF_ID_RegRt(IF_ID_RegRt), .IF_ID_UseRs(IF_ID_UseRs),
        .IF_ID_UseRt(IF_ID_UseRt), .IF_ID_UseHiLo(IF_ID_UseHiLo),
        .IDcontrol_Branch(IDcontrol_Branch), .IDcontrol_Jump(IDcontrol_Jump),
        .Branch_Taken(Branch_Taken), .MD_Start(MD_Start),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Clear(ID_EX_Clear), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             ex_rd, ex_rw;
        logic [REG_AW-1:0] ex_wr;
        logic             mem_rd;
        logic [REG_AW-1:0] mem_wr, rs, rt;
        logic             use_rs, use_rt, br, jmp, taken;
        logic             e_pcw, e_ifw, e_flush, e_clr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string name, input logic pcw, input logic ifw,
                            input logic fl, input logic clr);
        chk({name, ".PCWrite"},     int'(PCWrite),     int'(pcw));
        chk({name, ".IF_ID_Write"}, int'(IF_ID_Write), int'(ifw));
        chk({name, ".IF_ID_Flush"}, int'(IF_ID_Flush), int'(fl));
        chk({name, ".ID_EX_Clear"}, int'(ID_EX_Clear), int'(clr));
    endtask

    task automatic clear_inputs();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_WriteReg = '0;
        EX_MEM_MemRead = 0; EX_MEM_WriteReg = '0;
        IF_ID_RegRs = '0; IF_ID_RegRt = '0; IF_ID_UseRs = 0; IF_ID_UseRt = 0;
        IF_ID_UseHiLo = 0; IDcontrol_Branch = 0; IDcontrol_Jump = 0;
        Branch_Taken = 0; MD_Start = 0;
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Advance to the next drive point (posedge + 1).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_WriteReg = 5'd8;
        IF_ID_RegRs = 5'd8; IF_ID_UseRs = 1;
    endtask

    initial begin
        //           name         exrd exrw exwr mrd mwr  rs  rt urs urt br jmp tk  pcw ifw fl clr
        vecs[0]  = '{"lu_rs",      1, 1, 5'd8, 0, 5'd0, 5'd8, 5'd2, 1, 0, 0, 0, 0,  0, 0, 0, 1};
        vecs[1]  = '{"lu_r0",      1, 1, 5'd0, 0, 5'd0, 5'd0, 5'd2, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        vecs[2]  = '{"lu_nouse",   1, 1, 5'd8, 0, 5'd0, 5'd8, 5'd2, 0, 0, 0, 0, 0,  1, 1, 0, 0};
        vecs[3]  = '{"lu_rt",      1, 1, 5'd8, 0, 5'd0, 5'd1, 5'd8, 0, 1, 0, 0, 0,  0, 0, 0, 1};
        vecs[4]  = '{"alu_fwd",    0, 1, 5'd8, 0, 5'd0, 5'd8, 5'd2, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        vecs[5]  = '{"br_ex",      0, 1, 5'd9, 0, 5'd0, 5'd9, 5'd2, 1, 0, 1, 0, 0,  0, 0, 0, 1};
        vecs[6]  = '{"br_mem",     0, 0, 5'd0, 1, 5'd9, 5'd9, 5'd2, 1, 0, 1, 0, 1,  0, 0, 0, 1};
        vecs[7]  = '{"br_mem_alu", 0, 0, 5'd0, 0, 5'd9, 5'd9, 5'd2, 1, 0, 1, 0, 0,  1, 1, 0, 0};
        vecs[8]  = '{"br_taken",   0, 0, 5'd0, 0, 5'd0, 5'd9, 5'd2, 1, 0, 1, 0, 1,  1, 1, 1, 0};
        vecs[9]  = '{"jr_ex",      0, 1, 5'd5, 0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 1, 0,  0, 0, 0, 1};
        vecs[10] = '{"j_clean",    0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  1, 1, 1, 0};
        vecs[11] = '{"br_tk_stall",1, 1, 5'd4, 0, 5'd0, 5'd3, 5'd4, 1, 1, 1, 0, 1,  0, 0, 0, 1};
        vecs[12] = '{"br_nt_other",0, 1, 5'd9, 0, 5'd0, 5'd3, 5'd2, 1, 0, 1, 0, 0,  1, 1, 0, 0};

        clear_inputs();
        reset = 1'b1;
        #12;
        chk_ctrl("in_reset", 1, 1, 0, 0);
        chk("in_reset.md_busy", int'(md_busy), 0);
        chk("in_reset.stall_cycles", int'(stall_cycles), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_ctrl("after_reset", 1, 1, 0, 0);

        // Single-cycle vectors, each from a fresh reset.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            ID_EX_MemRead = vecs[i].ex_rd;  ID_EX_RegWrite = vecs[i].ex_rw;
            ID_EX_WriteReg = vecs[i].ex_wr; EX_MEM_MemRead = vecs[i].mem_rd;
            EX_MEM_WriteReg = vecs[i].mem_wr;
            IF_ID_RegRs = vecs[i].rs; IF_ID_RegRt = vecs[i].rt;
            IF_ID_UseRs = vecs[i].use_rs; IF_ID_UseRt = vecs[i].use_rt;
            IDcontrol_Branch = vecs[i].br; IDcontrol_Jump = vecs[i].jmp;
            Branch_Taken = vecs[i].taken;
            @(negedge clk);
            chk_ctrl(vecs[i].name, vecs[i].e_pcw, vecs[i].e_ifw, vecs[i].e_flush, vecs[i].e_clr);
            next_cycle();
            chk({vecs[i].name, ".stall_cycles"}, int'(stall_cycles), int'(vecs[i].e_clr));
        end

        // beq $9 behind a lw $9: br_ex, then br_mem, then the taken redirect.
        do_reset();
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_WriteReg = 5'd9;
        IF_ID_RegRs = 5'd9; IF_ID_UseRs = 1; IDcontrol_Branch = 1; Branch_Taken = 1;
        @(negedge clk);
        chk_ctrl("ldbr_c1", 0, 0, 0, 1);
        next_cycle();
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_WriteReg = '0;
        EX_MEM_MemRead = 1; EX_MEM_WriteReg = 5'd9;
        @(negedge clk);
        chk_ctrl("ldbr_c2", 0, 0, 0, 1);
        next_cycle();
        EX_MEM_MemRead = 0; EX_MEM_WriteReg = '0;
        @(negedge clk);
        chk_ctrl("ldbr_c3", 1, 1, 1, 0);
        chk("ldbr.stall_cycles", int'(stall_cycles), 2);

        // j with FLUSH_CYCLES=3; a load-use pattern in IF/ID is ignored during the flush.
        do_reset();
        IDcontrol_Jump = 1;
        @(negedge clk);
        chk_ctrl("flush_c0", 1, 1, 1, 0);
        next_cycle();
        clear_inputs();
        set_load_use();
        @(negedge clk);
        chk_ctrl("flush_c1", 1, 1, 1, 0);
        next_cycle();
        @(negedge clk);
        chk_ctrl("flush_c2", 1, 1, 1, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk_ctrl("flush_c3", 1, 1, 0, 0);
        chk("flush.stall_cycles", int'(stall_cycles), 0);

        // MD_Start with mflo already in ID: no stall that cycle, then 4 stall cycles.
        do_reset();
        MD_Start = 1; IF_ID_UseHiLo = 1;
        @(negedge clk);
        chk_ctrl("md_c0", 1, 1, 0, 0);
        chk("md_c0.md_busy", int'(md_busy), 0);
        next_cycle();
        MD_Start = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("md_c%0d.md_busy", c), int'(md_busy), (c <= 4) ? 1 : 0);
            chk($sformatf("md_c%0d.PCWrite", c), int'(PCWrite), (c <= 4) ? 0 : 1);
            chk($sformatf("md_c%0d.ID_EX_Clear", c), int'(ID_EX_Clear), (c <= 4) ? 1 : 0);
            next_cycle();
        end
        chk("md.stall_cycles", int'(stall_cycles), 4);

        // Restart on busy cycle 2 keeps md_busy high for 4 more cycles.
        do_reset();
        MD_Start = 1;
        next_cycle();
        MD_Start = 0;
        for (int c = 1; c <= 7; c++) begin
            MD_Start = (c == 2);
            @(negedge clk);
            chk($sformatf("mdre_c%0d.md_busy", c), int'(md_busy), (c <= 6) ? 1 : 0);
            next_cycle();
        end
        MD_Start = 0;

        // Asynchronous reset while flushing and busy.
        do_reset();
        set_load_use();
        MD_Start = 1;
        next_cycle();
        clear_inputs();
        IDcontrol_Jump = 1;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("rst_mid.IF_ID_Flush", int'(IF_ID_Flush), 1);
        chk("rst_mid.md_busy", int'(md_busy), 1);
        chk("rst_mid.stall_cycles", int'(stall_cycles), 1);
        #2;
        set_load_use();
        reset = 1'b1;
        #1;
        chk_ctrl("rst_async", 1, 1, 0, 0);
        chk("rst_async.md_busy", int'(md_busy), 0);
        chk("rst_async.stall_cycles", int'(stall_cycles), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk_ctrl("rst_after", 1, 1, 0, 0);
        chk("rst_after.md_busy", int'(md_busy), 0);

        // 20 stalled cycles saturate the 4-bit counter at 15.
        do_reset();
        set_load_use();
        repeat (20) next_cycle();
        @(negedge clk);
        chk("sat.stall_cycles", int'(stall_cycles), 15);
        chk("sat.PCWrite", int'(PCWrite), 0);
        next_cycle();
        chk("sat_hold.stall_cycles", int'(stall_cycles), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
